// File: rtl/writeback_stage3_if.sv
// Stage-3 writeback control bus: stage-2 requests and memory valid in, register-file
// enables, stall and hazard/status flags out.
interface writeback_stage3_if;
    logic [2:0] A_sel_in;
    logic       A_en_in;
    logic [2:0] X_sel_in;
    logic       X_en_in;
    logic       ld_mem_in;
    logic       mem_rd_valid;
    logic [2:0] A_sel;
    logic       A_en;
    logic [2:0] X_sel;
    logic       X_en;
    logic       stall;
    logic       A_pending;
    logic       X_pending;
    logic       protocol_err;
    logic       mem_timeout;

    modport master (
        output A_sel_in, A_en_in, X_sel_in, X_en_in, ld_mem_in, mem_rd_valid,
        input  A_sel, A_en, X_sel, X_en, stall, A_pending, X_pending, protocol_err, mem_timeout
    );

    modport slave (
        input  A_sel_in, A_en_in, X_sel_in, X_en_in, ld_mem_in, mem_rd_valid,
        output A_sel, A_en, X_sel, X_en, stall, A_pending, X_pending, protocol_err, mem_timeout
    );
endinterface

// File: rtl/writeback_stage3.sv
// Stage-3 writeback controller of the pipelined BPF CPU: passes stage-2 writes through and
// holds the pipeline on outstanding packet-memory loads. Optional abort: WRITEBACK_STAGE3_MEM_TIMEOUT_EN.
module writeback_stage3 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage3_if.slave bus
);

    localparam int unsigned CNT_W = 16;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    typedef struct packed {
        logic [2:0] a_sel;
        logic       a_en;
        logic [2:0] x_sel;
        logic       x_en;
    } wb_req_t;

    logic [0:0] state_q;
    logic [0:0] state_nxt;
    wb_req_t    req_in;
    wb_req_t    req_q;
    wb_req_t    req_out_c;
    logic       latch_c;
    logic       stall_c;
    logic       a_pend_c;
    logic       x_pend_c;
    logic       timeout_c;
    logic       timeout_hit_c;
    logic       perr_q;

    assign req_in = '{a_sel: bus.A_sel_in, a_en: bus.A_en_in,
                      x_sel: bus.X_sel_in, x_en: bus.X_en_in};

`ifdef WRITEBACK_STAGE3_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts WAIT_MEM cycles; value k-1 in the k-th WAIT_MEM cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (latch_c) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_MEM) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit_c = (state_q == WAIT_MEM) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [CNT_W-1:0] unused_timeout_cycles;
    assign unused_timeout_cycles = CNT_W'(TIMEOUT_CYCLES);
    assign timeout_hit_c         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (latch_c) begin
                req_q <= req_in;
            end
            // Any non-bubble while waiting is a stage-2 protocol violation.
            if ((state_q == WAIT_MEM) && (bus.A_en_in || bus.X_en_in || bus.ld_mem_in)) begin
                perr_q <= 1'b1;
            end
        end
    end

    // Next state and outputs; everything idles at zero so stage outputs can be OR-combined.
    always_comb begin
        state_nxt = state_q;
        req_out_c = '0;
        latch_c   = 1'b0;
        stall_c   = 1'b0;
        a_pend_c  = 1'b0;
        x_pend_c  = 1'b0;
        timeout_c = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    a_pend_c = bus.A_en_in;
                    x_pend_c = bus.X_en_in;
                    if (bus.ld_mem_in && !bus.mem_rd_valid) begin
                        latch_c   = 1'b1;
                        stall_c   = 1'b1;
                        state_nxt = WAIT_MEM;
                    end else begin
                        req_out_c = req_in;
                    end
                end
                WAIT_MEM: begin
                    stall_c  = 1'b1;
                    a_pend_c = req_q.a_en;
                    x_pend_c = req_q.x_en;
                    if (bus.mem_rd_valid) begin
                        req_out_c = req_q;
                        stall_c   = 1'b0;
                        state_nxt = IDLE;
                    end else if (timeout_hit_c) begin
                        timeout_c = 1'b1;
                        stall_c   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.A_sel        = req_out_c.a_sel;
    assign bus.A_en         = req_out_c.a_en;
    assign bus.X_sel        = req_out_c.x_sel;
    assign bus.X_en         = req_out_c.x_en;
    assign bus.stall        = stall_c;
    assign bus.A_pending    = a_pend_c;
    assign bus.X_pending    = x_pend_c;
    assign bus.protocol_err = perr_q;
    assign bus.mem_timeout  = timeout_c;

endmodule

// File: tb/tb_writeback_stage3.sv
// Scoreboard bench for writeback_stage3: driver queues expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_writeback_stage3;

`ifdef WRITEBACK_STAGE3_MEM_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    typedef struct {
        string      name;
        logic [12:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    exp_t sb[$];

    writeback_stage3_if bus ();

    writeback_stage3 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {A_sel, A_en, X_sel, X_en, stall, A_pending, X_pending, protocol_err, mem_timeout}.
    function automatic logic [12:0] ev(input logic [2:0] as, input logic ae, input logic [2:0] xs,
                                       input logic xe, input logic st, input logic ap,
                                       input logic xp, input logic pe, input logic tm);
        return {as, ae, xs, xe, st, ap, xp, pe, tm};
    endfunction

    task automatic step(input string nm, input logic r, input logic [2:0] as, input logic ae,
                        input logic [2:0] xs, input logic xe, input logic ld, input logic vl,
                        input logic [12:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        rst_n            = r;
        bus.A_sel_in     = as;
        bus.A_en_in      = ae;
        bus.X_sel_in     = xs;
        bus.X_en_in      = xe;
        bus.ld_mem_in    = ld;
        bus.mem_rd_valid = vl;
        item.name = nm;
        item.v    = e;
        sb.push_back(item);
    endtask

    task automatic bubble(input string nm, input logic vl, input logic [12:0] e);
        step(nm, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, vl, e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [12:0] act;
            e   = sb.pop_front();
            act = {bus.A_sel, bus.A_en, bus.X_sel, bus.X_en, bus.stall, bus.A_pending,
                   bus.X_pending, bus.protocol_err, bus.mem_timeout};
            checks++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: got %b expected %b (sel/en/sel/en/stall/ap/xp/perr/tmo)",
                         e.name, act, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.A_sel_in = '0; bus.A_en_in = 1'b0; bus.X_sel_in = '0; bus.X_en_in = 1'b0;
        bus.ld_mem_in = 1'b0; bus.mem_rd_valid = 1'b0;

        step("reset0", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0);
        step("reset_gated", 1'b0, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, '0);
        bubble("post_reset", 1'b0, '0);

        // Pass-through, then stray valid ignored in IDLE.
        step("pass_a", 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, ev(3'd3,1,3'd0,0,0,1,0,0,0));
        bubble("pass_a_next", 1'b0, '0);
        step("pass_ax_vld", 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, ev(3'd2,1,3'd6,1,0,1,1,0,0));
        bubble("pass_vld_idle", 1'b1, '0);

        // Delayed load: valid four cycles after issue.
        step("dload_issue", 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        for (int i = 0; i < 3; i++) bubble("dload_wait", 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        bubble("dload_valid", 1'b1, ev(3'd0,0,3'd5,1,0,0,1,0,0));
        bubble("dload_idle", 1'b0, '0);

        // Same-cycle load.
        step("sload", 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, ev(3'd4,1,3'd0,0,0,1,0,0,0));
        bubble("sload_idle", 1'b0, '0);

        // Protocol error during a dual-register load.
        step("perr_issue", 1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,1,1,0,0));
        bubble("perr_wait", 1'b0, ev(3'd0,0,3'd0,0,1,1,1,0,0));
        step("perr_bad_in", 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, ev(3'd0,0,3'd0,0,1,1,1,0,0));
        bubble("perr_set", 1'b0, ev(3'd0,0,3'd0,0,1,1,1,1,0));
        bubble("perr_complete", 1'b1, ev(3'd1,1,3'd7,1,0,1,1,1,0));
        bubble("perr_sticky", 1'b0, ev(3'd0,0,3'd0,0,0,0,0,1,0));

        // Reset while waiting discards the pending write.
        step("rst_issue", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,1,0,1,0));
        bubble("rst_wait", 1'b0, ev(3'd0,0,3'd0,0,1,1,0,1,0));
        step("rst_low", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0);
        bubble("rst_late_vld", 1'b1, '0);
        bubble("rst_idle", 1'b0, '0);
        step("rst_pass", 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, ev(3'd5,1,3'd0,0,0,1,0,0,0));

`ifdef WRITEBACK_STAGE3_MEM_TIMEOUT_EN
        // Abort after eight stall cycles, then valid arriving in the limit cycle wins.
        step("to_issue", 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        for (int i = 0; i < 7; i++) bubble("to_wait", 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        bubble("to_abort", 1'b0, ev(3'd0,0,3'd0,0,0,0,1,0,1));
        bubble("to_idle", 1'b0, '0);
        step("to2_issue", 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,1,0,0,0));
        for (int i = 0; i < 7; i++) bubble("to2_wait", 1'b0, ev(3'd0,0,3'd0,0,1,1,0,0,0));
        bubble("to2_vld_wins", 1'b1, ev(3'd6,1,3'd0,0,0,1,0,0,0));
        bubble("to2_idle", 1'b0, '0);
`else
        // Without the abort, stall holds until data returns.
        step("hold_issue", 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        for (int i = 0; i < 11; i++) bubble("hold_wait", 1'b0, ev(3'd0,0,3'd0,0,1,0,1,0,0));
        bubble("hold_valid", 1'b1, ev(3'd0,0,3'd3,1,0,0,1,0,0));
        bubble("hold_idle", 1'b0, '0);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/writeback_stage3.md
Name: writeback_stage3

Overview:
- Stage 3 (writeback) controller of the pipelined BPF CPU; directly downstream of the stage-2 compute controller.
- Consumes stage 2's registered A/X select/enable and its registered packet-memory read enable.
- Drives the A and X register-file enables to the datapath, and stalls stages 0–2 while a packet-memory load is outstanding.
- Outputs go to zero whenever the stage is inactive, so multi-stage control outputs can be combined by logical OR.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_MEM before abort. Used only with the optional feature; legal range is 1..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- A_sel_in  in  3  A source select, registered by stage 2.
- A_en_in  in  1  A write request from stage 2.
- X_sel_in  in  3  X source select from stage 2.
- X_en_in  in  1  X write request from stage 2.
- ld_mem_in  in  1  stage 2's registered packet_mem_rd_en; the write source is packet-memory read data.
- mem_rd_valid  in  1  packet-memory read data valid this cycle.
- A_sel  out  3  A mux select to datapath.
- A_en  out  1  A register write enable.
- X_sel  out  3  X mux select to datapath.
- X_en  out  1  X register write enable.
- stall  out  1  hold stages 0–2; issue bubbles into stage 2.
- A_pending  out  1  A write outstanding (for stage-1 RAW hazard check).
- X_pending  out  1  X write outstanding.
- protocol_err  out  1  sticky: a non-bubble arrived while in WAIT_MEM.
- mem_timeout  out  1  one-cycle pulse on load abort (optional feature only).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, latched sel/en cleared, protocol_err=0, timeout counter=0.
  - All outputs read 0 during reset and in the cycle after reset release, unless IDLE pass-through applies in that cycle.
  - Reset during WAIT_MEM discards the pending write; no A_en/X_en is produced for it.
- FSM has two states: IDLE and WAIT_MEM.
- IDLE, ld_mem_in=0:
  - Pass-through: A_sel/A_en/X_sel/X_en equal the inputs in the same cycle (zero latency). Stage 2 already registers them.
  - stall=0.
- IDLE, ld_mem_in=1, mem_rd_valid=1:
  - Same-cycle pass-through, no stall, stay in IDLE.
- IDLE, ld_mem_in=1, mem_rd_valid=0:
  - Latch A_sel_in/A_en_in/X_sel_in/X_en_in, then go to WAIT_MEM.
  - Outputs in this cycle: A_en=0, X_en=0, both sels=0.
  - stall=1 combinationally in this same cycle.
- WAIT_MEM:
  - stall=1.
  - A_pending = latched A_en; X_pending = latched X_en.
  - A_en/X_en = 0 and sels = 0 until mem_rd_valid.
  - On mem_rd_valid=1: drive latched sels/enables for exactly that cycle, stall=0, return to IDLE.
  - Inputs are ignored in WAIT_MEM. If A_en_in, X_en_in or ld_mem_in is 1 in any WAIT_MEM cycle, set protocol_err (sticky until reset).
- A_pending/X_pending in IDLE equal A_en_in/X_en_in, i.e. the write lands this cycle.
- If both latched enables are set, both registers are written in the same cycle.
- mem_rd_valid while IDLE with ld_mem_in=0 is ignored.

Optional Feature:
- Macro: WRITEBACK_STAGE3_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle.
  - If the counter reaches TIMEOUT_CYCLES with mem_rd_valid=0, then in that cycle: mem_timeout=1, no A_en/X_en, stall=0, return to IDLE.
  - mem_rd_valid in the timeout cycle takes priority: normal write, no pulse.
- Undefined:
  - No counter is built and mem_timeout is tied to 0.
  - WAIT_MEM lasts indefinitely.

Test Plan:
- IDLE pass-through: A_sel_in=3, A_en_in=1, ld_mem_in=0 for 1 cycle -> A_sel=3, A_en=1 in the same cycle; stall=0; outputs 0 the next cycle with bubble inputs.
- Delayed load: X_sel_in=5, X_en_in=1, ld_mem_in=1, with mem_rd_valid rising 4 cycles later ->
  - stall high for exactly 4 cycles;
  - X_pending=1 throughout;
  - X_en=1, X_sel=5 only in the valid cycle;
  - then IDLE.
- Same-cycle load: ld_mem_in=1, A_en_in=1, mem_rd_valid=1 together -> A_en=1 immediately, stall never asserts.
- Protocol error: during WAIT_MEM drive A_en_in=1 for 1 cycle -> protocol_err=1 and stays 1 after returning to IDLE; the pending write still completes with the latched values only.
- Reset mid-operation: enter WAIT_MEM, pull rst low for 1 cycle, then assert mem_rd_valid -> no A_en/X_en produced, stall=0, state IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=8): load with no valid -> mem_timeout pulses once; stall=1 for 8 cycles then 0; no enables. With the macro undefined, the same stimulus -> stall held until mem_rd_valid.
